pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, load-use bubbles and
// branch flushes, plus a saturating stalled-cycle counter.
module pipeline_ctrl #(
    parameter int unsigned FLUSH_DEPTH = 2  // legal range 1..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_s,
    input  logic [4:0]  id_rs2_s,
    input  logic        ex_valid,
    input  logic        ex_mem_re,
    input  logic [4:0]  ex_rd_s,
    input  logic        br_taken,
    output logic        move,
    output logic        forward_stall,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

    state_t      state_reg, state_next;
    logic        d_pend_reg, d_pend_next;
    logic        i_done_reg, i_done_next;
    logic [2:0]  flush_cnt_reg, flush_cnt_next;
    logic [31:0] stall_cnt_reg, stall_cnt_next;

    logic        flush_active;
    logic        br_accept;
    logic        ld_use;
    logic [4:0]  id_rs_s [2];
    logic [1:0]  rs_hit;

    assign id_rs_s[0] = id_rs1_s;
    assign id_rs_s[1] = id_rs2_s;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign rs_hit[gi] = (id_rs_s[gi] == ex_rd_s);
    end

    // A fetch or data response that arrived early is remembered in i_done/d_pend.
    assign move         = !rst && (imem_resp || i_done_reg) && (!d_pend_reg || dmem_resp);
    assign flush_active = (flush_cnt_reg != 3'd0);
    assign br_accept    = br_taken && ex_valid && move && !flush_active;
    assign redirect     = br_accept;
    assign flush        = !rst && (flush_active || br_accept);
    assign ld_use       = ex_valid && ex_mem_re && (ex_rd_s != 5'd0) && id_valid && (|rs_hit);
    assign forward_stall = ld_use && move && !flush;
    assign stall_cnt    = stall_cnt_reg;

    always_comb begin
        state_next     = state_reg;
        d_pend_next    = d_pend_reg;
        i_done_next    = i_done_reg;
        flush_cnt_next = flush_cnt_reg;
        stall_cnt_next = stall_cnt_reg;

        // A new request wins over a response landing in the same cycle.
        if (dmem_req && move)
            d_pend_next = 1'b1;
        else if (dmem_resp)
            d_pend_next = 1'b0;

        if (move)
            i_done_next = 1'b0;
        else if (imem_resp)
            i_done_next = 1'b1;

        if (br_accept)
            flush_cnt_next = FLUSH_LOAD;
        else if (flush_active && move)
            flush_cnt_next = flush_cnt_reg - 3'd1;

        if ((!move || forward_stall) && (stall_cnt_reg != 32'hFFFF_FFFF))
            stall_cnt_next = stall_cnt_reg + 32'd1;

        case (state_reg)
            RUN: begin
                if (!move)
                    state_next = STALL;
                else if (flush_cnt_next != 3'd0)
                    state_next = FLUSH;
            end
            STALL: begin
                if (move)
                    state_next = (flush_cnt_next != 3'd0) ? FLUSH : RUN;
            end
            FLUSH: begin
                if (!move)
                    state_next = STALL;
                else if (flush_cnt_next == 3'd0)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            d_pend_reg    <= 1'b0;
            i_done_reg    <= 1'b0;
            flush_cnt_reg <= 3'd0;
            stall_cnt_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            d_pend_reg    <= d_pend_next;
            i_done_reg    <= i_done_next;
            flush_cnt_reg <= flush_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

endmodule
